// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
//
// Multi-channel input debouncer. Each channel synchronizes its raw input, then
// a four-state FSM (LOW, WAIT_HI, HIGH, WAIT_LO) requires the synchronized
// level to stay at the new value for T consecutive cycles before the
// debounced output follows it. T is the shared stable_cnt, with 0 read as 1.
//
// Per-channel mode (mode[2i+1:2i]):
//   00 both edges debounced
//   01 rising edge debounced, falling edge taken immediately
//   10 falling edge debounced, rising edge taken immediately
//   11 bypass: out follows the synchronized input one cycle later
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in         raw asynchronous channel inputs        [N_CH]
//   stable_cnt required consecutive stable cycles     [CNT_W]
//   mode       per-channel mode, 2 bits per channel   [2*N_CH]
//   out        registered debounced level             [N_CH]
//   rise       one-cycle pulse on out 0->1            [N_CH]
//   fall       one-cycle pulse on out 1->0            [N_CH]
//   busy       channel is waiting for stability       [N_CH]
// -----------------------------------------------------------------------------
module debounce_multi #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     in,
  input  logic [CNT_W-1:0]    stable_cnt,
  input  logic [2*N_CH-1:0]   mode,
  output logic [N_CH-1:0]     out,
  output logic [N_CH-1:0]     rise,
  output logic [N_CH-1:0]     fall,
  output logic [N_CH-1:0]     busy
);

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    WAIT_HI = 2'd1,
    HIGH    = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic [1:0] MODE_BOTH = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;

  // A threshold of zero would never be reachable; treat it as one cycle.
  function automatic logic [CNT_W-1:0] eff_thresh(input logic [CNT_W-1:0] raw);
    return (raw == '0) ? CNT_W'(1) : raw;
  endfunction

  // ---- stage p0..pN: input synchronizer ----
  logic [N_CH-1:0] sync_p [SYNC_STAGES];
  logic [N_CH-1:0] s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_p[k] <= '0;
    end else begin
      sync_p[0] <= in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_p[k] <= sync_p[k-1];
    end
  end

  assign s = sync_p[SYNC_STAGES-1];

  // Shared threshold, decoded once for all channels.
  logic [CNT_W-1:0] thr;
  logic             t_one;

  assign thr   = eff_thresh(stable_cnt);
  assign t_one = (thr == CNT_W'(1));

  // ---- per-channel debounce FSM and registered outputs ----
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [CNT_W:0]   count_inc;
    logic             reached;
    logic [1:0]       md, md_q;
    logic             rise_db, fall_db, mode_chg;
    logic             out_q, rise_q, fall_q, busy_q;
    logic             out_nxt;

    assign md       = mode[2*i +: 2];
    assign rise_db  = (md == MODE_BOTH) || (md == MODE_RISE);
    assign fall_db  = (md == MODE_BOTH) || (md == MODE_FALL);
    assign mode_chg = (md != md_q);

    // One extra bit so count+1 >= T is exact even at T = 2^CNT_W-1.
    assign count_inc = {1'b0, count} + (CNT_W+1)'(1);
    assign reached   = (count_inc >= {1'b0, thr});

    always_comb begin
      state_nxt = state;
      count_nxt = count;
      unique case (state)
        LOW: begin
          count_nxt = '0;
          if (s[i]) begin
            if (rise_db && !t_one) begin
              state_nxt = WAIT_HI;
              count_nxt = CNT_W'(1);
            end else begin
              state_nxt = HIGH;
            end
          end
        end
        HIGH: begin
          count_nxt = '0;
          if (!s[i]) begin
            if (fall_db && !t_one) begin
              state_nxt = WAIT_LO;
              count_nxt = CNT_W'(1);
            end else begin
              state_nxt = LOW;
            end
          end
        end
        WAIT_HI: begin
          // A mode change abandons the pending edge; restart from the
          // current level under the new mode on the following cycle.
          if (mode_chg) begin
            state_nxt = LOW;
            count_nxt = '0;
          end else if (s[i]) begin
            if (reached) begin
              state_nxt = HIGH;
              count_nxt = '0;
            end else begin
              count_nxt = count_inc[CNT_W-1:0];
            end
          end else begin
            state_nxt = LOW;
            count_nxt = '0;
          end
        end
        WAIT_LO: begin
          if (mode_chg) begin
            state_nxt = HIGH;
            count_nxt = '0;
          end else if (!s[i]) begin
            if (reached) begin
              state_nxt = LOW;
              count_nxt = '0;
            end else begin
              count_nxt = count_inc[CNT_W-1:0];
            end
          end else begin
            state_nxt = HIGH;
            count_nxt = '0;
          end
        end
        default: begin
          state_nxt = LOW;
          count_nxt = '0;
        end
      endcase
    end

    assign out_nxt = (state_nxt == HIGH) || (state_nxt == WAIT_LO);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state  <= LOW;
        count  <= '0;
        md_q   <= '0;
        out_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        state  <= state_nxt;
        count  <= count_nxt;
        md_q   <= md;
        out_q  <= out_nxt;
        rise_q <= out_nxt & ~out_q;
        fall_q <= ~out_nxt & out_q;
        busy_q <= (state_nxt == WAIT_HI) || (state_nxt == WAIT_LO);
      end
    end

    assign out[i]  = out_q;
    assign rise[i] = rise_q;
    assign fall[i] = fall_q;
    assign busy[i] = busy_q;
  end

endmodule
